// File: rtl/register_file_sb_if.sv
// register_file_sb_if: read, writeback and reserve bus between issue/writeback and the register file
interface register_file_sb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int LOG2_REGISTERS = 5,
  parameter int READ_PORTS     = 2
);
  logic [READ_PORTS*LOG2_REGISTERS-1:0] rd_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data;
  logic [READ_PORTS-1:0]                rd_ready;
  logic                                 wb_en;
  logic [LOG2_REGISTERS-1:0]            wb_addr;
  logic [DATA_WIDTH-1:0]                wb_data;
  logic                                 rsv_en;
  logic [LOG2_REGISTERS-1:0]            rsv_addr;
  logic [LOG2_REGISTERS-1:0]            busy_count;
  logic                                 wb_spurious;
  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
    input  rd_data, rd_ready, busy_count, wb_spurious
  );
  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
    output rd_data, rd_ready, busy_count, wb_spurious
  );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with writeback bypass and busy scoreboard
module register_file_sb #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTERS      = 32,
  parameter int LOG2_REGISTERS = 5,
  parameter int READ_PORTS     = 2,
  parameter bit BYPASS         = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_sb_if.slave  bus
);
  logic [DATA_WIDTH-1:0]          regs_q [REGISTERS];
  logic [DATA_WIDTH-1:0]          regs_d [REGISTERS];
  logic [REGISTERS-1:0]           busy_q, busy_d;
  logic [LOG2_REGISTERS-1:0]      busy_count_q, busy_count_d;
  logic                           wb_spurious_q, wb_spurious_d;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]          rd_ready;
  // next array/scoreboard state; a same-cycle reserve overrides the writeback clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    busy_count_d = '0;
    for (int r = 1; r < REGISTERS; r++) begin
      if (bus.wb_en && bus.wb_addr == LOG2_REGISTERS'(r)) begin
        regs_d[r] = bus.wb_data;
        busy_d[r] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr == LOG2_REGISTERS'(r)) busy_d[r] = 1'b1;
      busy_count_d = busy_count_d + LOG2_REGISTERS'(busy_d[r]);
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    wb_spurious_d = bus.wb_en && bus.wb_addr != '0 && !busy_q[bus.wb_addr] &&
                    !(bus.rsv_en && bus.rsv_addr == bus.wb_addr);
  end
  // combinational read ports: x0 is zero, then bypass, then array
  always_comb begin
    rd_data = '0;
    rd_ready = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
        bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS] == '0 ? '0 :
        (BYPASS && bus.wb_en && bus.wb_addr == bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS]) ? bus.wb_data :
        regs_q[bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS]];
      rd_ready[p] =
        bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS] == '0 ||
        (BYPASS && bus.wb_en && bus.wb_addr == bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS]) ||
        !busy_q[bus.rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS]];
    end
  end
  // state registers with synchronous active-low reset overriding all strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REGISTERS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      busy_count_q <= '0;
      wb_spurious_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      busy_count_q <= busy_count_d;
      wb_spurious_q <= wb_spurious_d;
    end
  end
  assign bus.rd_data = rd_data;
  assign bus.rd_ready = rd_ready;
  assign bus.busy_count = busy_count_q;
  assign bus.wb_spurious = wb_spurious_q;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of reads, bypass, scoreboard and reset
module tb_register_file_sb;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_bad = 0;
  register_file_sb_if #(.DATA_WIDTH(32), .LOG2_REGISTERS(5), .READ_PORTS(2)) bus ();
  register_file_sb #(.DATA_WIDTH(32), .REGISTERS(32), .LOG2_REGISTERS(5), .READ_PORTS(2), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wb_en = 1'b0;
    bus.rsv_en = 1'b0;
    bus.wb_addr = '0;
    bus.rsv_addr = '0;
    bus.wb_data = '0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    bus.rd_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    rd(5'd5, 5'd0);
    chk("rst_d0", bus.rd_data[31:0], 32'h0);
    chk("rst_d1", bus.rd_data[63:32], 32'h0);
    chk("rst_rdy", 32'(bus.rd_ready), 32'h3);
    chk("rst_cnt", 32'(bus.busy_count), 32'd0);
    chk("rst_spur", 32'(bus.wb_spurious), 32'd0);
    bus.rsv_en = 1'b1;
    bus.rsv_addr = 5'd3;
    rd(5'd3, 5'd0);
    chk("rsv_same_cycle_rdy", 32'(bus.rd_ready[0]), 32'd1);
    tick();
    idle();
    rd(5'd3, 5'd0);
    chk("x3_busy_rdy", 32'(bus.rd_ready[0]), 32'd0);
    chk("x3_busy_cnt", 32'(bus.busy_count), 32'd1);
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("x3_byp_data", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("x3_byp_rdy", 32'(bus.rd_ready[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("x3_wb_cnt", 32'(bus.busy_count), 32'd0);
    chk("x3_wb_spur", 32'(bus.wb_spurious), 32'd0);
    chk("x3_arr_data", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("x3_arr_rdy", 32'(bus.rd_ready[0]), 32'd1);
    bus.rsv_en = 1'b1;
    bus.rsv_addr = 5'd7;
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd7;
    bus.wb_data = 32'h1234;
    tick();
    idle();
    rd(5'd7, 5'd0);
    chk("x7_data", bus.rd_data[31:0], 32'h1234);
    chk("x7_rdy", 32'(bus.rd_ready[0]), 32'd0);
    chk("x7_cnt", 32'(bus.busy_count), 32'd1);
    chk("x7_spur", 32'(bus.wb_spurious), 32'd0);
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd9;
    bus.wb_data = 32'h55;
    tick();
    idle();
    rd(5'd0, 5'd9);
    chk("x9_data", bus.rd_data[63:32], 32'h55);
    chk("x9_rdy", 32'(bus.rd_ready[1]), 32'd1);
    chk("x9_spur_hi", 32'(bus.wb_spurious), 32'd1);
    chk("x9_cnt", 32'(bus.busy_count), 32'd1);
    tick();
    chk("x9_spur_lo", 32'(bus.wb_spurious), 32'd0);
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hFFFFFFFF;
    bus.rsv_en = 1'b1;
    bus.rsv_addr = 5'd0;
    rd(5'd0, 5'd0);
    chk("x0_same_data", bus.rd_data[31:0], 32'h0);
    chk("x0_same_rdy", 32'(bus.rd_ready[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("x0_data", bus.rd_data[63:32], 32'h0);
    chk("x0_rdy", 32'(bus.rd_ready), 32'h3);
    chk("x0_cnt", 32'(bus.busy_count), 32'd1);
    chk("x0_spur", 32'(bus.wb_spurious), 32'd0);
    for (int r = 1; r < 32; r++) begin
      bus.rsv_en = 1'b1;
      bus.rsv_addr = 5'(r);
      tick();
    end
    idle();
    rd(5'd5, 5'd31);
    chk("all_cnt", 32'(bus.busy_count), 32'd31);
    chk("all_rdy", 32'(bus.rd_ready), 32'h0);
    rst_n = 1'b0;
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd4;
    bus.wb_data = 32'hAA;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("post_rst_cnt", 32'(bus.busy_count), 32'd0);
    chk("post_rst_spur", 32'(bus.wb_spurious), 32'd0);
    for (int r = 1; r < 32; r++) begin
      rd(5'(r), 5'(r));
      chk($sformatf("post_rst_d%0d", r), bus.rd_data[31:0], 32'h0);
      chk($sformatf("post_rst_r%0d", r), 32'(bus.rd_ready), 32'h3);
    end
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'h77;
    tick();
    idle();
    rd(5'd3, 5'd0);
    chk("late_wb_data", bus.rd_data[31:0], 32'h77);
    chk("late_wb_spur", 32'(bus.wb_spurious), 32'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
